dmem_bus_ctrl: RTL and testbench

- Memory-stage data-memory controller sitting directly downstream of the datapath's M stage.
- Consumes the M-stage address, store data and byte enables, and runs a ready-handshaked transaction on the external data bus.
- Returns read_data_M and data_mem_ack to the datapath; the hazard unit holds stall_M while ack is low.
- Bounds every bus transaction with a timeout and flags failures on bus_err.

---
 rtl/dmem_bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: M-stage data-memory controller driving a ready-handshaked bus.
// Every bus access is bounded by TIMEOUT_CYCLES. A timed-out access raises bus_err.
// A timed-out read also returns ERR_RDATA.
// Optional macro DMEM_POSTED_WRITE_EN: writes are acked at once and drained from a
// one-entry posted-write buffer alongside the pipeline.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic [3:0]  byte_en_M,
  input  logic        advance_M,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             req_present;
  logic             can_accept;
  logic             tmo_hit;
  logic             addr_lsb_unused;

  assign req_present     = mem_read_M | mem_write_M;
  assign tmo_hit         = (tmo_cnt == CNT_LAST);
  assign addr_lsb_unused = ^alu_out_M[1:0];

`ifdef DMEM_POSTED_WRITE_EN
  logic pw_busy;

  // New accesses wait in IDLE while a posted write is still on the bus
  assign can_accept = req_present & ~pw_busy;
`else
  assign can_accept = req_present;
`endif

  // Access FSM with registered bus and pipeline-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      read_data_M  <= '0;
      data_mem_ack <= 1'b0;
      bus_err      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
`ifdef DMEM_POSTED_WRITE_EN
      pw_busy      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          data_mem_ack <= 1'b0;
          if (can_accept) begin
            // Write wins when both request lines are set
            bus_we    <= mem_write_M;
            bus_addr  <= alu_out_M[31:2];
            bus_wdata <= write_data_M;
            bus_be    <= mem_write_M ? byte_en_M : 4'hF;
            bus_err   <= 1'b0;
            bus_req   <= 1'b1;
            tmo_cnt   <= '0;
`ifdef DMEM_POSTED_WRITE_EN
            if (mem_write_M) begin
              pw_busy      <= 1'b1;
              data_mem_ack <= 1'b1;
              state        <= DONE;
            end else begin
              state <= REQ;
            end
`else
            state <= REQ;
`endif
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req      <= 1'b0;
            data_mem_ack <= 1'b1;
            if (!bus_we) read_data_M <= bus_rdata;
            state        <= DONE;
          end else if (tmo_hit) begin
            bus_req      <= 1'b0;
            bus_err      <= 1'b1;
            data_mem_ack <= 1'b1;
            if (!bus_we) read_data_M <= ERR_RDATA;
            state        <= DONE;
          end else begin
            tmo_cnt <= CNT_W'(tmo_cnt + CNT_W'(1));
          end
        end
        DONE: begin
          // Held until the pipeline advances; the access is never re-issued
          if (advance_M) begin
            data_mem_ack <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          data_mem_ack <= 1'b0;
          bus_req      <= 1'b0;
          state        <= IDLE;
        end
      endcase
`ifdef DMEM_POSTED_WRITE_EN
      // Posted-write buffer drains independently of the pipeline handshake
      if (pw_busy) begin
        if (bus_ready) begin
          bus_req <= 1'b0;
          pw_busy <= 1'b0;
        end else if (tmo_hit) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
          pw_busy <= 1'b0;
        end else begin
          tmo_cnt <= CNT_W'(tmo_cnt + CNT_W'(1));
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: the driver queues the expected ack response.
// A monitor pops and checks the queue on every rising edge of data_mem_ack.
module tb_dmem_bus_ctrl;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERRV = 32'hBAD0_BAD0;
`ifdef DMEM_POSTED_WRITE_EN
  localparam int STORE_BASE_LAT = 1;
`else
  localparam int STORE_BASE_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read_M = 1'b0;
  logic        mem_write_M = 1'b0;
  logic [31:0] alu_out_M = '0;
  logic [31:0] write_data_M = '0;
  logic [3:0]  byte_en_M = '0;
  logic        advance_M = 1'b1;
  logic [31:0] read_data_M;
  logic        data_mem_ack;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERRV)) dut (
    .clk(clk), .reset(reset),
    .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .alu_out_M(alu_out_M), .write_data_M(write_data_M), .byte_en_M(byte_en_M),
    .advance_M(advance_M),
    .read_data_M(read_data_M), .data_mem_ack(data_mem_ack), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  // Monitor: one scoreboard entry per rising edge of ack
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_ack = 1'b0;
    end else begin
      if (data_mem_ack && !prev_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("read_data_M", read_data_M, e.rd);
          chk("bus_err", 32'(bus_err), 32'(e.err));
        end
      end
      prev_ack = data_mem_ack;
    end
  end

  // Bus responder: asserts ready in REQ cycle index wait_cfg (-1 = never)
  int          wait_cfg = 0;
  int          req_cycles = 0;
  int          last_len = 0;
  int          n_pulses = 0;
  logic [29:0] obs_addr = '0;
  logic [31:0] obs_wdata = '0;
  logic [3:0]  obs_be = '0;
  logic        obs_we = 1'b0;
  logic        unstable = 1'b0;
  always @(negedge clk) begin
    if (bus_req) begin
      if (req_cycles == 0) begin
        n_pulses++;
        obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be; obs_we = bus_we;
        unstable = 1'b0;
      end else if (bus_addr !== obs_addr || bus_wdata !== obs_wdata ||
                   bus_be !== obs_be || bus_we !== obs_we) begin
        unstable = 1'b1;
      end
      bus_ready = (req_cycles == wait_cfg);
      req_cycles++;
    end else begin
      if (req_cycles > 0) last_len = req_cycles;
      req_cycles = 0;
      bus_ready = 1'b0;
    end
  end

  // One access: queue expectation, wait for ack, hold DONE for 'hold' cycles, check bus side
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] rdata, input int wait_n, input int lat,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int hold, input int exp_len);
    exp_t e;
    int   n;
    int   p0;
    @(posedge clk); #1;
    bus_rdata = rdata; wait_cfg = wait_n; p0 = n_pulses;
    mem_read_M = rd; mem_write_M = wr; alu_out_M = addr;
    write_data_M = wdata; byte_en_M = be; advance_M = (hold == 0);
    e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
    q.push_back(e);
    @(posedge clk); #1;
    chk("err_clear_on_accept", 32'(bus_err), 32'd0);
    n = 0;
    while (!data_mem_ack && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!data_mem_ack) chk("ack_wait_expired", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("ack_held", 32'(data_mem_ack), 32'd1);
      if (i == hold - 1) begin
        mem_read_M = 1'b0; mem_write_M = 1'b0; advance_M = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (hold == 0) begin
      mem_read_M = 1'b0; mem_write_M = 1'b0; advance_M = 1'b1;
      @(posedge clk); #1;
    end
    chk("ack_release", 32'(data_mem_ack), 32'd0);
    n = 0;
    while (bus_req && n < 300) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk); #1;
    chk("req_len", 32'(last_len), 32'(exp_len));
    chk("req_pulses", 32'(n_pulses - p0), 32'd1);
    chk("bus_addr", 32'(obs_addr), {2'b00, addr[31:2]});
    chk("bus_be", 32'(obs_be), wr ? 32'(be) : 32'hF);
    chk("bus_we", 32'(obs_we), 32'(wr));
    if (wr) chk("bus_wdata", obs_wdata, wdata);
    chk("bus_stable", 32'(unstable), 32'd0);
  endtask

  // Global bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int n;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_data_M, 32'd0);
    chk("rst_ack", 32'(data_mem_ack), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    reset = 1'b0;

    // Load, ready in first REQ cycle
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 0, 2,
              32'h1234_5678, 1'b0, 0, 1);
    // Store, 3 wait cycles; read data untouched
    do_access(1'b0, 1'b1, 32'h0000_0022, 32'hAABB_CCDD, 4'b0100, 32'hFFFF_FFFF, 3,
              STORE_BASE_LAT + ((STORE_BASE_LAT == 2) ? 3 : 0),
              32'h1234_5678, 1'b0, 0, 4);
    // Load with the pipeline stalled 4 cycles in DONE
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 3,
              32'hCAFE_F00D, 1'b0, 4, 2);
    // Read with both request lines set: write wins
    do_access(1'b1, 1'b1, 32'h0000_0044, 32'h0102_0304, 4'b1001, 32'h7777_7777, 0,
              STORE_BASE_LAT, 32'hCAFE_F00D, 1'b0, 0, 1);
    // Load that never sees ready: timeout after 8 REQ cycles
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h5555_5555, -1, 9,
              ERRV, 1'b1, 0, 8);
    // Next accepted access clears bus_err
    do_access(1'b0, 1'b1, 32'h0000_0030, 32'h1122_3344, 4'b0011, 32'h0, 0,
              STORE_BASE_LAT, ERRV, 1'b0, 0, 1);

    // Reset during REQ
    @(posedge clk); #1;
    wait_cfg = -1; mem_read_M = 1'b1; alu_out_M = 32'h0000_0080; advance_M = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("req_before_reset", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_ack", 32'(data_mem_ack), 32'd0);
    chk("reset_read_data", read_data_M, 32'd0);
    mem_read_M = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // Fresh transaction after reset
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h5A5A_A5A5, 2, 4,
              32'h5A5A_A5A5, 1'b0, 0, 3);

`ifdef DMEM_POSTED_WRITE_EN
    // Posted store followed back-to-back by a load
    @(posedge clk); #1;
    c = cyc;
    wait_cfg = 3;
    mem_write_M = 1'b1; mem_read_M = 1'b0; alu_out_M = 32'h0000_0200;
    write_data_M = 32'hDEAD_0001; byte_en_M = 4'hF; advance_M = 1'b1;
    e.rd = 32'h5A5A_A5A5; e.err = 1'b0; e.cyc = c + 1;
    q.push_back(e);
    @(posedge clk); #1;
    chk("posted_store_ack", 32'(data_mem_ack), 32'd1);
    mem_write_M = 1'b0; mem_read_M = 1'b1; alu_out_M = 32'h0000_0300;
    bus_rdata = 32'h0BAD_CAFE;
    e.rd = 32'h0BAD_CAFE; e.err = 1'b0; e.cyc = c + 10;
    q.push_back(e);
    repeat (3) begin
      @(posedge clk); #1;
      chk("posted_load_held", 32'(data_mem_ack), 32'd0);
    end
    n = 0;
    while (!data_mem_ack && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!data_mem_ack) chk("posted_ack_wait_expired", 32'd0, 32'd1);
    mem_read_M = 1'b0;
    @(posedge clk); #1;
    chk("posted_ack_release", 32'(data_mem_ack), 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
